// File: rtl/dlfloat_host_link.sv
// dlfloat_host_link
//   Host-side partner of the dlfloat MAC tile pin protocol. Operand pairs accepted on a
//   valid/ready port are time-multiplexed onto the 16-bit tile input bus. The A word is
//   registered at the accept edge and the B word at the following edge. The tile's 8-bit
//   output stream (high byte, then low byte) is reassembled into 16-bit results. The results
//   are queued in a result FIFO that is drained over a valid/ready port.
//
// Ports
//   clk, rst_n           shared clock / async active-low reset (tile uses the same reset)
//   op_valid/op_ready    operand pair handshake; accept only at phase-0 edges
//   op_a, op_b           dlfloat operands
//   pin_out              to tile {uio_in, ui_in}
//   pin_in               from tile uo_out
//   res_valid/res_ready  result handshake, res_data is the registered FIFO head
//   busy                 pairs in flight or results still queued
//
// Optional feature (macro DLF_HOST_NAN_FLAG_EN)
//   res_nan    sticky flag, set when a pushed result equals 16'hFFFF
//   nan_count  4-bit saturating count of such pushes
module dlfloat_host_link #(
    parameter int unsigned RESULT_LAT = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [15:0] pin_out,
    input  logic [7:0]  pin_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
`ifdef DLF_HOST_NAN_FLAG_EN
    output logic        res_nan,
    output logic [3:0]  nan_count,
`endif
    output logic        busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + RESULT_LAT + 2) + 1;

    logic                  phase_q, phase_d;
    logic                  run_q;
    logic [RESULT_LAT-1:0] tag_q, tag_d;
    logic [15:0]           b_q, b_d;
    logic [15:0]           pin_out_q, pin_out_d;
    logic [7:0]            hi_q, hi_d;
    logic [15:0]           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  res_valid_q, res_valid_d;
    logic [15:0]           res_data_q, res_data_d;

    logic                  accept;
    logic                  push;
    logic                  mem_pop;
    logic [15:0]           cap_word;
    logic [OccW-1:0]       inflight;
    logic [OccW-1:0]       occupancy;

    // Credit: every queued result plus every pair in flight owns one FIFO slot, so a
    // completing pair always finds room.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RESULT_LAT); i++) begin
            inflight = inflight + OccW'(tag_q[i]);
        end
        occupancy = OccW'(count_q) + OccW'(res_valid_q) + inflight;
        // run_q keeps op_ready low until the first edge after reset release.
        op_ready  = run_q & ~phase_q & (occupancy < OccW'(FIFO_DEPTH));
        accept    = op_valid & op_ready;
    end

    assign cap_word = {hi_q, pin_in};
    assign push     = ~phase_q & tag_q[RESULT_LAT-1];
    // The head register refills from storage contents that existed before this edge, so a
    // push into an empty FIFO is visible one cycle later.
    assign mem_pop  = (count_q != '0) & (~res_valid_q | res_ready);

    always_comb begin
        phase_d   = ~phase_q;
        tag_d     = tag_q;
        b_d       = b_q;
        hi_d      = hi_q;
        pin_out_d = 16'h0000;
        if (!phase_q) begin
            tag_d[0] = accept;
            for (int i = 1; i < int'(RESULT_LAT); i++) begin
                tag_d[i] = tag_q[i-1];
            end
            if (accept) begin
                pin_out_d = op_a;
                b_d       = op_b;
            end
        end else begin
            hi_d = pin_in;
            // tag_q[0] still marks whether the previous phase-0 edge accepted a pair.
            if (tag_q[0]) begin
                pin_out_d = b_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PtrW'(push);
        rd_ptr_d    = rd_ptr_q + PtrW'(mem_pop);
        count_d     = count_q + CntW'(push) - CntW'(mem_pop);
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (mem_pop) begin
            res_valid_d = 1'b1;
            res_data_d  = mem_q[rd_ptr_q];
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 1'b0;
            run_q       <= 1'b0;
            tag_q       <= '0;
            b_q         <= 16'h0000;
            pin_out_q   <= 16'h0000;
            hi_q        <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
        end else begin
            phase_q     <= phase_d;
            run_q       <= 1'b1;
            tag_q       <= tag_d;
            b_q         <= b_d;
            pin_out_q   <= pin_out_d;
            hi_q        <= hi_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_word;
        end
    end

    assign pin_out   = pin_out_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (inflight != '0) | res_valid_q | (count_q != '0);

`ifdef DLF_HOST_NAN_FLAG_EN
    logic       nan_q, nan_d;
    logic [3:0] nan_cnt_q, nan_cnt_d;
    logic       nan_push;

    assign nan_push = push & (cap_word == 16'hFFFF);

    always_comb begin
        nan_d     = nan_q | nan_push;
        nan_cnt_d = nan_cnt_q;
        if (nan_push && (nan_cnt_q != 4'hF)) begin
            nan_cnt_d = nan_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q     <= 1'b0;
            nan_cnt_q <= 4'h0;
        end else begin
            nan_q     <= nan_d;
            nan_cnt_q <= nan_cnt_d;
        end
    end

    assign res_nan   = nan_q;
    assign nan_count = nan_cnt_q;
`endif

endmodule

// File: tb/tb_dlfloat_host_link.sv
module tb_dlfloat_host_link;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic [15:0] pin_out;
    logic [7:0]  pin_in = 8'h0;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;
`ifdef DLF_HOST_NAN_FLAG_EN
    logic        res_nan;
    logic [3:0]  nan_count;
`endif

    dlfloat_host_link #(.RESULT_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .pin_out   (pin_out),
        .pin_in    (pin_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
`ifdef DLF_HOST_NAN_FLAG_EN
        .res_nan   (res_nan),
        .nan_count (nan_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [15:0] exp_q [$];
    logic [1:0]  rdy_mode = 2'd1;   // 0: hold low, 1: hold high, 2: random
    logic        rdy_rand = 1'b1;
    logic        chk_spacing = 1'b0;
    logic        have_prev = 1'b0;
    int          prev_pop = 0;

    assign res_ready = (rdy_mode == 2'd2) ? rdy_rand : rdy_mode[0];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        rdy_rand = ($urandom_range(0, 3) != 0);
    end

    // Bench phase: 0 out of reset, toggling every edge afterwards.
    logic ph = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph <= 1'b0;
        else        ph <= ~ph;
    end

    // Tile loopback stub. Each pair period, the word shown on pin_out in the phase-1 cycle
    // (the A slot, or 0 when idle) is recorded. The bytes of the slot recorded LAT-1 periods
    // before the current one are returned: hi in phase 1, lo in phase 0. This way, the word
    // completing at a phase-0 edge is the A issued LAT pairs earlier.
    logic [15:0] hist [$];
    logic [15:0] stub_word = 16'h0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hist.delete();
            stub_word = 16'h0;
            pin_in    = 8'h0;
        end else if (ph) begin
            hist.push_back(pin_out);
            if (hist.size() >= LAT) stub_word = hist.pop_front();
            else                    stub_word = 16'h0;
            pin_in = stub_word[15:8];
        end else begin
            pin_in = stub_word[7:0];
        end
    end

    // Scoreboard monitor: every consumed result must be the oldest outstanding A word.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h, expected none (t=%0t)", res_data, $time);
            end else begin
                chk("result", res_data, exp_q.pop_front());
                if (chk_spacing && have_prev) chk("result_spacing", cyc - prev_pop, 2);
                have_prev = 1'b1;
                prev_pop  = cyc;
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        while (!op_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got op_ready 0, expected 1 within 100 cycles");
            op_valid = 1'b0;
            return;
        end
        exp_q.push_back(a);
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        acc_cyc  = cyc;
        chk("pin_out_a", pin_out, a);
        @(posedge clk);
        #1;
        chk("pin_out_b", pin_out, b);
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    task automatic set_rdy(input logic [1:0] m);
        @(posedge clk);
        #1;
        rdy_mode = m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pin_out"}, pin_out, 0);
        chk({tag, "_op_ready"}, op_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_busy"}, busy, 0);
`ifdef DLF_HOST_NAN_FLAG_EN
        chk({tag, "_res_nan"}, res_nan, 0);
        chk({tag, "_nan_count"}, nan_count, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int bad;
        int t;
        logic [15:0] ra;

        #1;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing driven, nothing produced.
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pin_out != 16'h0 || res_valid || busy) bad++;
        end
        chk("idle_cycles_with_activity", bad, 0);

        // Single pair with latency measurement.
        send(16'h3E00, 16'h3E00);
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("single_res_valid", res_valid, 1);
        chk("single_latency", cyc - acc_cyc, 2 * LAT + 1);
        wait_drain(100);

        // Back-to-back pairs, consumer always ready.
        have_prev   = 1'b0;
        chk_spacing = 1'b1;
        send(16'h3E00, 16'h1111);
        send(16'h4000, 16'h2222);
        send(16'h4200, 16'h3333);
        send(16'h4400, 16'h4444);
        wait_drain(100);
        chk_spacing = 1'b0;

        // Credit limit: with the consumer stalled, only DEPTH pairs are accepted.
        set_rdy(2'd0);
        for (int i = 0; i < DEPTH; i++) send(16'h5000 + 16'(i), 16'h0A00 + 16'(i));
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (op_ready) bad++;
        end
        chk("credit_op_ready_cycles", bad, 0);
        chk("credit_res_valid", res_valid, 1);
        chk("credit_busy", busy, 1);
        set_rdy(2'd1);
        send(16'h5100, 16'h0B00);
        send(16'h5101, 16'h0B01);
        wait_drain(200);

        // Reset with two pairs in flight and one result queued.
        set_rdy(2'd0);
        send(16'h6000, 16'h0);
        send(16'h6001, 16'h0);
        send(16'h6002, 16'h0);
        chk("pre_reset_res_valid", res_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_rdy(2'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid) bad++;
        end
        chk("stale_result_cycles", bad, 0);
        chk("post_reset_busy", busy, 0);

        // Randomized traffic with a randomly stalling consumer.
        set_rdy(2'd2);
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom_range(0, 16'hFFFE));
            send(ra, 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_drain(600);
        set_rdy(2'd1);

`ifdef DLF_HOST_NAN_FLAG_EN
        do_reset();
        chk("nan_initial", res_nan, 0);
        send(16'hFFFF, 16'h3C00);
        send(16'h3E00, 16'h3C00);
        wait_drain(100);
        chk("nan_sticky", res_nan, 1);
        chk("nan_count", nan_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
